// File: rtl/random_delay_gen.sv
// random_delay_gen
//   After a start press, waits MIN_DELAY + (pseudo-random 0..2^RANGE_BITS-1)
//   clock ticks, then raises and holds random_finish until clear or reset.
//   A react press during the wait is flagged as a false start.
// Ports:
//   clock          system clock, rising edge
//   reset          synchronous, active-high, overrides all other inputs
//   start          start button level (debounced upstream)
//   react          react button level
//   clear          one-cycle pulse ending the round
//   random_finish  high from delay expiry until clear/reset
//   busy           high while waiting
//   false_start    high after a react press during the wait
//   delay_value    delay latched for the current round
module random_delay_gen #(
    parameter int unsigned MIN_DELAY  = 1000,
    parameter int unsigned RANGE_BITS = 12,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        react,
    input  logic        clear,
    output logic        random_finish,
    output logic        busy,
    output logic        false_start,
    output logic [15:0] delay_value
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE, FAULT} state_t;

    localparam logic [15:0] RANGE_MASK = 16'((32'd1 << RANGE_BITS) - 32'd1);
    localparam logic [15:0] TAPS       = 16'hB400;

    state_t      state, state_next;
    logic [15:0] lfsr, lfsr_next;
    logic [15:0] cnt, cnt_next;
    logic [15:0] delay_next;
    logic        prev_start, prev_react;
    logic        start_edge, react_edge;

    assign start_edge = start & ~prev_start;
    assign react_edge = react & ~prev_react;
    assign lfsr_next  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : '0);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        delay_next = delay_value;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        // Random part comes from the LFSR value before this cycle's advance.
                        delay_next = 16'(MIN_DELAY) + (lfsr & RANGE_MASK);
                        cnt_next   = delay_next - 16'd1;
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (react_edge) begin
                        state_next = FAULT;
                    end else if (cnt == '0) begin
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt - 16'd1;
                    end
                end
                DONE:    state_next = DONE;
                FAULT:   state_next = FAULT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            lfsr          <= SEED;
            prev_start    <= 1'b0;
            prev_react    <= 1'b0;
            delay_value   <= '0;
            random_finish <= 1'b0;
            busy          <= 1'b0;
            false_start   <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            lfsr          <= lfsr_next;
            prev_start    <= start;
            prev_react    <= react;
            delay_value   <= delay_next;
            // Outputs registered from the next state so they track state exactly.
            random_finish <= (state_next == DONE);
            busy          <= (state_next == WAIT);
            false_start   <= (state_next == FAULT);
        end
    end

endmodule

// File: tb/tb_random_delay_gen.sv
// tb_random_delay_gen
//   Directed steps plus randomized input traffic, compared every cycle
//   against a timestamp-based reference model of the round behaviour.
module tb_random_delay_gen;

    localparam int unsigned MIN = 5;
    localparam int unsigned RB  = 2;
    localparam logic [15:0] SD  = 16'hACE1;

    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_DONE  = 2;
    localparam int M_FAULT = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        react = 1'b0;
    logic        clear = 1'b0;
    logic        random_finish;
    logic        busy;
    logic        false_start;
    logic [15:0] delay_value;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    random_delay_gen #(
        .MIN_DELAY (MIN),
        .RANGE_BITS(RB),
        .SEED      (SD)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .react        (react),
        .clear        (clear),
        .random_finish(random_finish),
        .busy         (busy),
        .false_start  (false_start),
        .delay_value  (delay_value)
    );

    // Reference model: round mode plus the absolute cycle at which the wait ends.
    int          m_mode = M_IDLE;
    logic [15:0] m_lfsr = SD;
    logic [15:0] m_delay = '0;
    logic        m_ps = 1'b0;
    logic        m_pr = 1'b0;
    longint      cyc = 0;
    longint      finish_at = 0;

    always @(posedge clock) begin
        cyc = cyc + 1;
        if (reset) begin
            m_mode  = M_IDLE;
            m_lfsr  = SD;
            m_delay = '0;
            m_ps    = 1'b0;
            m_pr    = 1'b0;
        end else begin
            if (clear) begin
                m_mode = M_IDLE;
            end else if (m_mode == M_IDLE && start && !m_ps) begin
                m_delay   = 16'(MIN + (int'(m_lfsr) % (1 << RB)));
                finish_at = cyc + longint'(m_delay);
                m_mode    = M_WAIT;
            end else if (m_mode == M_WAIT) begin
                if (react && !m_pr)       m_mode = M_FAULT;
                else if (cyc == finish_at) m_mode = M_DONE;
            end
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            m_ps   = start;
            m_pr   = react;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        chk("model_finish", {15'd0, random_finish}, {15'd0, m_mode == M_DONE});
        chk("model_busy",   {15'd0, busy},          {15'd0, m_mode == M_WAIT});
        chk("model_fs",     {15'd0, false_start},   {15'd0, m_mode == M_FAULT});
        chk("model_delay",  delay_value, m_delay);
        chk("model_lfsr",   dut.lfsr, m_lfsr);
    endtask

    task automatic chk_outs(input string tag, input logic f, input logic b, input logic s);
        chk({tag, "_finish"}, {15'd0, random_finish}, {15'd0, f});
        chk({tag, "_busy"},   {15'd0, busy},          {15'd0, b});
        chk({tag, "_fs"},     {15'd0, false_start},   {15'd0, s});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and LFSR sequence
        reset = 1'b1;
        step(); step();
        chk_outs("rst", 1'b0, 1'b0, 1'b0);
        chk("rst_delay", delay_value, 16'h0000);
        chk("rst_lfsr", dut.lfsr, 16'hACE1);
        reset = 1'b0;
        step(); chk("lfsr1", dut.lfsr, 16'hE270);
        step(); chk("lfsr2", dut.lfsr, 16'h7138);
        step(); chk("lfsr3", dut.lfsr, 16'h389C);

        // Nominal delay
        reset = 1'b1; step();
        reset = 1'b0; start = 1'b1;
        step();
        chk("nom_delay", delay_value, 16'd6);
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk_outs("nom_wait", 1'b0, 1'b1, 1'b0);
        end
        step();
        chk_outs("nom_done", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk_outs("nom_hold", 1'b1, 1'b0, 1'b0);
        end
        clear = 1'b1; step(); clear = 1'b0;
        chk_outs("nom_clear", 1'b0, 1'b0, 1'b0);
        chk("nom_delay_kept", delay_value, 16'd6);

        // False start
        reset = 1'b1; step();
        reset = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        react = 1'b1; step();
        react = 1'b0; step();
        chk_outs("fs_set", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk_outs("fs_hold", 1'b0, 1'b0, 1'b1);
        end
        clear = 1'b1; step(); clear = 1'b0;
        chk_outs("fs_clear", 1'b0, 1'b0, 1'b0);

        // Clear beats a start edge in IDLE; held start does not retrigger
        start = 1'b1; clear = 1'b1; step(); clear = 1'b0;
        chk_outs("pri_start", 1'b0, 1'b0, 1'b0);
        step();
        chk_outs("pri_held", 1'b0, 1'b0, 1'b0);
        start = 1'b0; step();

        // Clear beats a react edge in WAIT
        start = 1'b1; step();
        chk("pri_wait_busy", {15'd0, busy}, 16'd1);
        start = 1'b0; step();
        react = 1'b1; clear = 1'b1; step();
        react = 1'b0; clear = 1'b0;
        chk_outs("pri_react", 1'b0, 1'b0, 1'b0);
        step();
        chk_outs("pri_react2", 1'b0, 1'b0, 1'b0);

        // Start held across clear
        start = 1'b1; step();
        for (int i = 0; i < 8; i++) step();
        chk("held_done", {15'd0, random_finish}, 16'd1);
        clear = 1'b1; step(); clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_outs("held_idle", 1'b0, 1'b0, 1'b0);
        end
        start = 1'b0; step();
        start = 1'b1; step();
        chk("held_repress", {15'd0, busy}, 16'd1);

        // Reset mid-WAIT
        start = 1'b0;
        step(); step();
        reset = 1'b1; step(); reset = 1'b0;
        chk_outs("mid_rst", 1'b0, 1'b0, 1'b0);
        chk("mid_rst_delay", delay_value, 16'h0000);
        chk("mid_rst_lfsr", dut.lfsr, 16'hACE1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) start = ~start;
            if ($urandom_range(0, 9) == 0) react = ~react;
            clear = ($urandom_range(0, 24) == 0);
            reset = ($urandom_range(0, 149) == 0);
            step();
            if (m_delay != 16'd0) begin
                chk("rand_range", {15'd0, (delay_value >= 16'(MIN)) && (delay_value <= 16'(MIN + 3))}, 16'd1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
